// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Produces a registered grant index, its valid flag and the matching one-hot grant vector.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid
);

    localparam int            CW      = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    others;
    logic [3:0]    pick_mask;
    logic [1:0]    winner;

    // First set bit of mask, scanning upward from p with wrap-around.
    function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] result;
        logic       found;
        result = p;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && mask[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        others    = req & ~(4'b0001 << id_q);
        pick_mask = (state_q == BUSY) ? others : req;
        winner    = pick(pick_mask, ptr_q);

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_d = BUSY;
                    id_d    = winner;
                    cnt_d   = '0;
                    ptr_d   = winner + 2'd1;
                end
            end
            BUSY: begin
                // Counter saturates so a solo holder can keep the grant forever.
                if (req[id_q] && (cnt_q != CNT_MAX || others == 4'b0000)) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (others != 4'b0000) begin
                    id_d  = winner;
                    cnt_d = '0;
                    ptr_d = winner + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign grant_id    = id_q;
    assign grant       = grant_valid ? (4'b0001 << id_q) : 4'b0000;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource between requesters. It produces a registered 2-bit grant index and the matching one-hot grant vector, which is the 2-to-4 decode of the index gated by `grant_valid`. A bounded hold count keeps any one requester from locking the resource while others wait. It sits between the requester blocks and the shared resource's select/enable logic.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester keeps the grant while another request is pending. Legal range 2..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request vector; bit i = requester i wants the resource.
- `grant`  out  4  one-hot grant. All-zero when `grant_valid`=0.
- `grant_id`  out  2  index of the current grant holder; meaningful only when `grant_valid`=1.
- `grant_valid`  out  1  resource currently granted.

## Operation
- Internal state:
  - FSM with states IDLE and BUSY.
  - 2-bit priority pointer `ptr`.
  - Hold counter `cnt`, width ceil(log2(MAX_HOLD)), saturating at MAX_HOLD-1.
- Arbitration function `pick(mask, ptr)`: the first set bit of `mask`, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE:
  - If `req`≠0: go to BUSY with `grant_id`←pick(req, ptr), `grant_valid`←1, `cnt`←0, `ptr`←winner+1 mod 4.
  - Otherwise stay in IDLE.
- BUSY, holder g:
  - `others` = req with bit g cleared.
  - Keep condition: req[g]=1 AND (cnt<MAX_HOLD-1 OR others=0). On keep, stay and set cnt←min(cnt+1, MAX_HOLD-1).
  - Release condition: req[g]=0, OR (cnt=MAX_HOLD-1 AND others≠0).
  - On release with others≠0: hand over directly to pick(others, ptr) with no idle cycle. Set cnt←0 and ptr←new winner+1.
  - On release with others=0: go to IDLE with `grant_valid`←0. `grant_id` keeps its last value; `ptr` is unchanged.
- `grant` = grant_valid ? (4'b0001 << grant_id) : 4'b0000. It is derived from the registered index and valid, so it is glitch-free and never has more than one bit set.
- Reset (asserted at any time, including mid-grant): state←IDLE, grant_valid←0, grant←0000, grant_id←00, ptr←0, cnt←0. This takes effect immediately, without waiting for a clock edge.

## Timing
- All outputs are registered and update only on the rising edge of `clk`, or asynchronously on reset.
- Grant latency: `req` sampled high at edge N → `grant` valid after edge N (1 cycle). There is no combinational path from `req` to any output.
- Release latency: holder drops `req` before edge N → at edge N the grant moves to the next requester or goes to 0000.
- Hold bound: with another request pending, the holder keeps the grant for at most MAX_HOLD consecutive cycles. The grant then switches at the next edge.
- Worst-case wait: a continuously requesting requester receives the grant within 3×MAX_HOLD+1 cycles.
- Simultaneous events:
  - Holder drop and hold expiry in the same cycle are handled as a single release.
  - A new request arriving on the release edge takes part in that edge's arbitration.
- Reset release: the first edge with rst_n=1 may grant immediately.
- Wrap-around: when ptr=3 and the winner is 3, ptr←0.

## Test plan
- Reset and single request:
  - With rst_n=0, all outputs are 0.
  - Release reset, assert req=0001 → after one edge grant=0001, grant_id=0, grant_valid=1.
  - Drop req → next edge grant=0000, grant_valid=0.
- Round robin under full load: req=1111 held, MAX_HOLD=8 → grant rotates 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles. There are no idle cycles between grants.
- Pointer after idle: grant 2, drop all requests, then assert req=0101 → grant goes to 0 (ptr=3, scan 3, 0) → grant=0001.
- Solo holder saturation: req=0010 held for 50 cycles → grant=0010 throughout. Then assert req[3] while cnt is saturated → grant=1000 on the following edge.
- Early release handover: holder 0 drops at cycle 3 with req=0110 → next edge grant=0010, and cnt restarts at 0.
- Reset mid-grant: pulse rst_n low between edges while grant=0100 → grant=0000 immediately. After release, ptr=0: with req=1100 → grant=0100.
